// File: rtl/regfile_sb_if.sv
// Decode/writeback bus of the scoreboarded register file.
// The master side drives reads, issues and writebacks; the slave side is the register file itself.
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic [NREAD*ADDR_W-1:0] rd_addr;
    logic [NREAD-1:0]        rd_req;
    logic [NREAD*DATA_W-1:0] rd_data;
    logic [NREAD-1:0]        rd_busy;
    logic                    rd_stall;
    logic                    iss_en;
    logic [ADDR_W-1:0]       iss_addr;
    logic                    iss_ok;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [DATA_W-1:0]       wr_data;
    logic                    flush;
    logic [31:0]             wb_count;
    logic [DATA_W-1:0]       dbg_wb_value;

    modport master (
        output rd_addr, rd_req, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data, rd_busy, rd_stall, iss_ok, wb_count, dbg_wb_value
    );

    modport slave (
        input  rd_addr, rd_req, iss_en, iss_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data, rd_busy, rd_stall, iss_ok, wb_count, dbg_wb_value
    );
endinterface

// File: rtl/regfile_sb.sv
// Register file with asynchronous read ports, a single synchronous write port,
// same-cycle write-through bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_sb_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0]       regs [DEPTH];
    logic [DEPTH-1:0]        busy;
    logic [DEPTH-1:0]        busy_next;
    logic [31:0]             wb_count_q;

    logic                    wr_commit;
    logic                    iss_zero;
    logic                    iss_ok_c;
    logic                    iss_fire;
    logic [ADDR_W-1:0]       ra;
    logic [NREAD*DATA_W-1:0] rd_data_c;
    logic [NREAD-1:0]        rd_busy_c;

    assign wr_commit = bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0));
    assign iss_zero  = (ZERO_REG != 0) && (bus.iss_addr == '0);
    assign iss_ok_c  = iss_zero || !busy[bus.iss_addr] ||
                       (bus.wr_en && (bus.wr_addr == bus.iss_addr));
    assign iss_fire  = bus.iss_en && iss_ok_c && !bus.flush && !iss_zero;

    // Issue is applied after the writeback clear so a same-register pair ends busy.
    always_comb begin
        busy_next = busy;
        if (bus.flush) begin
            busy_next = '0;
        end else begin
            if (wr_commit) busy_next[bus.wr_addr] = 1'b0;
            if (iss_fire)  busy_next[bus.iss_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            busy       <= '0;
            wb_count_q <= '0;
        end else begin
            if (wr_commit) begin
                regs[bus.wr_addr] <= bus.wr_data;
                wb_count_q        <= wb_count_q + 32'd1;
            end
            busy <= busy_next;
        end
    end

    // Hardwired zero takes priority over the bypass so a suppressed write never leaks through.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra        = '0;
        for (int k = 0; k < NREAD; k++) begin
            ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd_data_c[k*DATA_W +: DATA_W] = '0;
                rd_busy_c[k]                  = 1'b0;
            end else if (bus.wr_en && (bus.wr_addr == ra)) begin
                rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
                rd_busy_c[k]                  = 1'b0;
            end else begin
                rd_data_c[k*DATA_W +: DATA_W] = regs[ra];
                rd_busy_c[k]                  = busy[ra];
            end
        end
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.rd_busy      = rd_busy_c;
    assign bus.rd_stall     = |(bus.rd_req & rd_busy_c);
    assign bus.iss_ok       = iss_ok_c;
    assign bus.wb_count     = wb_count_q;
    assign bus.dbg_wb_value = bus.wr_data;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: expected values are queued when stimulus
// is driven and popped against DUT outputs sampled 1 ns after the drive.
module tb_regfile_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREAD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [31:0] obs;

    regfile_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.rd_addr  = '0;
        bus.rd_req   = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.flush    = 1'b0;
    endtask

    task automatic set_rd(input int a0, input int a1, input logic [1:0] req);
        bus.rd_addr = {5'(a1), 5'(a0)};
        bus.rd_req  = req;
    endtask

    task automatic test_reset();
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 32'h55;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
        tick();
        idle();
        set_rd(3, 0, 2'b01);
        bus.iss_addr = 5'd3;
        exp_q.push_back(32'h55); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL pre_reset_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[0]); total++;
        if (obs !== e) begin bad++; $display("FAIL pre_reset_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL pre_reset_count got=%h exp=%h", obs, e); end
        rst = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL reset_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL reset_count got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_stall got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.iss_ok); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_iss_ok got=%h exp=%h", obs, e); end
        #1;
        rst = 1'b0;
        idle();
    endtask

    task automatic test_bypass();
        tick();
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 32'hDEADBEEF;
        set_rd(5, 0, 2'b01);
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL bypass_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.dbg_wb_value; total++;
        if (obs !== e) begin bad++; $display("FAIL dbg_wb_value got=%h exp=%h", obs, e); end
        tick();
        bus.wr_en = 1'b0; bus.wr_data = '0;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL stored_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL bypass_count got=%h exp=%h", obs, e); end
    endtask

    task automatic test_zero_reg();
        tick();
        idle();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 32'h1234;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
        set_rd(5, 0, 2'b10);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[63:32]; total++;
        if (obs !== e) begin bad++; $display("FAIL zero_bypass_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[1]); total++;
        if (obs !== e) begin bad++; $display("FAIL zero_bypass_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.iss_ok); total++;
        if (obs !== e) begin bad++; $display("FAIL zero_iss_ok got=%h exp=%h", obs, e); end
        tick();
        idle();
        set_rd(5, 0, 2'b10);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[63:32]; total++;
        if (obs !== e) begin bad++; $display("FAIL zero_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[1]); total++;
        if (obs !== e) begin bad++; $display("FAIL zero_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL zero_count got=%h exp=%h", obs, e); end
    endtask

    task automatic test_scoreboard();
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        tick();
        idle();
        set_rd(7, 0, 2'b01);
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[0]); total++;
        if (obs !== e) begin bad++; $display("FAIL sb_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL sb_stall got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.iss_ok); total++;
        if (obs !== e) begin bad++; $display("FAIL sb_waw_iss_ok got=%h exp=%h", obs, e); end
        tick();
        bus.iss_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h42;
        exp_q.push_back(32'h42); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL sb_wb_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL sb_wb_stall got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.iss_ok); total++;
        if (obs !== e) begin bad++; $display("FAIL sb_wb_iss_ok got=%h exp=%h", obs, e); end
        tick();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 32'h42;
        tick();
        idle();
        set_rd(7, 0, 2'b01);
        exp_q.push_back(32'h42); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        #1;
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL issue_wins_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[0]); total++;
        if (obs !== e) begin bad++; $display("FAIL issue_wins_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL issue_wins_stall got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL sb_count got=%h exp=%h", obs, e); end
    endtask

    task automatic test_unused_port();
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
        tick();
        idle();
        set_rd(0, 9, 2'b00);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[1]); total++;
        if (obs !== e) begin bad++; $display("FAIL unused_busy got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL unused_stall got=%h exp=%h", obs, e); end
        bus.rd_req = 2'b10;
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL used_stall got=%h exp=%h", obs, e); end
    endtask

    task automatic test_flush();
        tick();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 5'd2;
        tick();
        bus.iss_addr = 5'd4;
        tick();
        idle();
        set_rd(2, 4, 2'b11);
        exp_q.push_back(32'd3);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy); total++;
        if (obs !== e) begin bad++; $display("FAIL pre_flush_busy got=%h exp=%h", obs, e); end
        bus.flush = 1'b1;
        bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 32'h10;
        tick();
        idle();
        set_rd(2, 4, 2'b11);
        exp_q.push_back(32'd0); exp_q.push_back(32'h10); exp_q.push_back(32'd4);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy); total++;
        if (obs !== e) begin bad++; $display("FAIL flush_busy_2_4 got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.rd_data[31:0]; total++;
        if (obs !== e) begin bad++; $display("FAIL flush_write_data got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL flush_count got=%h exp=%h", obs, e); end
        set_rd(6, 9, 2'b11);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy); total++;
        if (obs !== e) begin bad++; $display("FAIL flush_busy_6_9 got=%h exp=%h", obs, e); end
        e = exp_q.pop_front(); obs = 32'(bus.rd_stall); total++;
        if (obs !== e) begin bad++; $display("FAIL flush_stall got=%h exp=%h", obs, e); end
        set_rd(7, 0, 2'b01);
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); obs = 32'(bus.rd_busy[0]); total++;
        if (obs !== e) begin bad++; $display("FAIL flush_busy_7 got=%h exp=%h", obs, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            tick();
            idle();
            d = $urandom;
            bus.wr_en = 1'b1; bus.wr_addr = 5'(10 + i); bus.wr_data = d;
            exp_q.push_back(d);
        end
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            set_rd(0, 10 + i, 2'b10);
            #1;
            e = exp_q.pop_front(); obs = bus.rd_data[63:32]; total++;
            if (obs !== e) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, obs, e); end
        end
        exp_q.push_back(32'd8);
        e = exp_q.pop_front(); obs = bus.wb_count; total++;
        if (obs !== e) begin bad++; $display("FAIL b2b_count got=%h exp=%h", obs, e); end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_unused_port();
        test_flush();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised general-purpose register file for the pipelined core: multiple asynchronous read ports, one synchronous write port, and a per-register busy scoreboard. Write-through bypass lets a read that hits the register being written in the same cycle see the new data. Sits between decode (reads, issue marking) and writeback (write, busy clear). Drives the decode stall signal and the writeback debug trace.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NREAD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 hardwired to zero, never busy; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_addr  input  NREAD*ADDR_W  read indices, port k at bits [k*ADDR_W +: ADDR_W]
rd_req  input  NREAD  port k is actually used by the instruction in decode
rd_data  output  NREAD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rd_busy  output  NREAD  register on port k has a pending, unwritten result
rd_stall  output  1  OR over k of (rd_req[k] & rd_busy[k])
iss_en  input  1  decode issues an instruction that will write iss_addr
iss_addr  input  ADDR_W  destination of issuing instruction
iss_ok  output  1  issue permitted this cycle
wr_en  input  1  writeback valid
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback value
flush  input  1  squash all in-flight producers
wb_count  output  32  number of committed register writes since reset
dbg_wb_value  output  DATA_W  value presented on the write port (wr_data)

Behaviour:
- Reset (async, rst=1): all registers = 0, all busy bits = 0, wb_count = 0. Therefore rd_data = 0, rd_busy = 0, rd_stall = 0, iss_ok = 1 while in reset.
- Write: at posedge clk, if wr_en and not (ZERO_REG and wr_addr==0): reg[wr_addr] <= wr_data, busy[wr_addr] <= 0 (unless set by issue, see below), wb_count <= wb_count+1. wb_count wraps modulo 2**32. Suppressed writes to register 0 do not count.
- Read, combinational, per port k:
  - ZERO_REG and rd_addr==0 -> data 0, busy 0.
  - Otherwise, if wr_en and wr_addr==rd_addr -> data = wr_data (bypass) and busy 0.
  - Otherwise -> data = reg[rd_addr], busy = busy[rd_addr].
- Issue: iss_ok = 1 when:
  - ZERO_REG and iss_addr==0, or
  - busy[iss_addr]==0, or
  - wr_en and wr_addr==iss_addr (the old producer retires this cycle).
- On an issue with iss_en & iss_ok & !flush and (not ZERO_REG or iss_addr!=0): busy[iss_addr] <= 1 at posedge.
- iss_en with iss_ok=0 (WAW hazard) has no effect. Decode must hold the instruction.
- Simultaneous write and issue to the same register: the register takes wr_data and busy ends 1 (issue wins).
- Flush: at posedge, all busy bits <= 0 and any same-cycle issue is ignored. A same-cycle wr_en is still committed (data written, counted).
- Busy bits for distinct registers update independently in the same cycle.
- rd_stall, rd_busy, iss_ok and rd_data are purely combinational from current state and inputs; zero-cycle latency. Writes are visible in registered state one cycle after the edge, or in the same cycle via the bypass.
- dbg_wb_value = wr_data, combinational.

Test Plan:
- Reset then read: assert rst mid-run after writing reg3=0x55 -> immediately rd_data=0, wb_count=0, all rd_busy=0, iss_ok=1.
- Write/read with bypass: wr_en, wr_addr=5, wr_data=0xDEADBEEF while rd_addr port0=5 -> same-cycle rd_data0=0xDEADBEEF. Next cycle, without wr_en -> still 0xDEADBEEF. wb_count=1.
- Zero register: write 0x1234 to reg0, issue to reg0, read port1=0 -> rd_data1=0, rd_busy1=0, wb_count unchanged.
- Scoreboard:
  - Issue reg7. Next cycle, rd_req0=1, rd_addr0=7 -> rd_busy0=1, rd_stall=1, and iss_en to reg7 gives iss_ok=0.
  - Then wr_en reg7=0x42 -> same cycle rd_data0=0x42, rd_stall=0, iss_ok=1.
  - Issue+write reg7 together -> afterwards reg7=0x42, busy7=1.
- Unused port: reg9 busy, rd_addr1=9, rd_req1=0 -> rd_busy1=1, rd_stall=0.
- Flush: issue reg2, reg4. Then flush with iss_en reg6 and wr_en reg2=0x10 in the same cycle -> all busy=0, reg6 not busy, reg2=0x10, wb_count incremented by 1.
